// File: rtl/psrv32_pipe_pkg.sv
// rtl/psrv32_pipe_pkg.sv - shared PSRV32 pipeline types: writeback selects, MEM/WB entry, skid states
package psrv32_pipe_pkg;

    localparam int PIPE_XLEN   = 32;
    localparam int PIPE_REG_AW = 5;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_ZERO = 2'b11;

    typedef struct packed {
        logic [PIPE_XLEN-1:0]   data_read;
        logic [PIPE_XLEN-1:0]   alu_result;
        logic [PIPE_XLEN-1:0]   pc_plus4;
        logic [PIPE_REG_AW-1:0] write_reg;
        logic [1:0]             mem_to_reg;
        logic                   reg_write;
    } memwb_entry_t;

    // bit 0 = main entry valid, bit 1 = skid entry valid; skid is never valid without main
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_MAIN  = 2'b01,
        SKID_BOTH  = 2'b11
    } skid_state_t;

endpackage

// File: rtl/memwb_elastic_reg_if.sv
// rtl/memwb_elastic_reg_if.sv - MEM->WB handshake and payload bundle
interface memwb_elastic_reg_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic              flush_i;
    logic [XLEN-1:0]   data_read_i;
    logic [XLEN-1:0]   alu_result_i;
    logic [XLEN-1:0]   pc_plus4_i;
    logic [REG_AW-1:0] write_reg_i;
    logic [1:0]        mem_to_reg_i;
    logic              reg_write_i;

    logic              out_valid_o;
    logic              out_ready_i;
    logic [XLEN-1:0]   data_read_o;
    logic [XLEN-1:0]   alu_result_o;
    logic [XLEN-1:0]   pc_plus4_o;
    logic [REG_AW-1:0] write_reg_o;
    logic [1:0]        mem_to_reg_o;
    logic              reg_write_o;
    logic [XLEN-1:0]   wb_data_o;
    logic [CNT_W-1:0]  retired_o;

    modport master (
        output in_valid_i, flush_i, data_read_i, alu_result_i, pc_plus4_i,
               write_reg_i, mem_to_reg_i, reg_write_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_read_o, alu_result_o, pc_plus4_o,
               write_reg_o, mem_to_reg_o, reg_write_o, wb_data_o, retired_o
    );

    modport slave (
        input  in_valid_i, flush_i, data_read_i, alu_result_i, pc_plus4_i,
               write_reg_i, mem_to_reg_i, reg_write_i, out_ready_i,
        output in_ready_o, out_valid_o, data_read_o, alu_result_o, pc_plus4_o,
               write_reg_o, mem_to_reg_o, reg_write_o, wb_data_o, retired_o
    );
endinterface

// File: rtl/pipe_skid_buffer.sv
// rtl/pipe_skid_buffer.sv - generic two-entry elastic register (main + skid) with flush
module pipe_skid_buffer
    import psrv32_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    skid_state_t  state, state_next;
    logic [W-1:0] main_q, skid_q;
    logic         accept, drain;
    logic         load_main_in, load_main_skid, load_skid;

    // in_ready comes straight off the state flop, so out_ready never reaches it combinationally
    assign in_ready  = ~state[1];
    assign out_valid = state[0];
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SKID_EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: if (accept) begin
                    load_main_in = 1'b1;
                    state_next   = SKID_MAIN;
                end
                SKID_MAIN: if (drain) begin
                    if (accept) load_main_in = 1'b1;
                    else        state_next   = SKID_EMPTY;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = SKID_BOTH;
                end
                SKID_BOTH: if (drain) begin
                    load_main_skid = 1'b1;
                    state_next     = SKID_MAIN;
                end
                default: state_next = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_data;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_data;
        end
    end
endmodule

// File: rtl/memwb_elastic_reg.sv
// rtl/memwb_elastic_reg.sv - elastic MEM/WB register with writeback mux, x0 suppression, retire counter
module memwb_elastic_reg
    import psrv32_pipe_pkg::*;
#(
    parameter int XLEN   = PIPE_XLEN,
    parameter int REG_AW = PIPE_REG_AW,
    parameter int CNT_W  = 32
) (
    input logic                clk_i,
    input logic                reset_i,
    memwb_elastic_reg_if.slave bus
);
    localparam int ENTRY_W = $bits(memwb_entry_t);

    memwb_entry_t      in_entry, main_entry;
    logic [ENTRY_W-1:0] main_bits;
    logic              main_valid, drain;
    logic [XLEN-1:0]   wb_mux;
    logic [CNT_W-1:0]  retired_q;

    assign in_entry = '{
        data_read:  bus.data_read_i,
        alu_result: bus.alu_result_i,
        pc_plus4:   bus.pc_plus4_i,
        write_reg:  bus.write_reg_i,
        mem_to_reg: bus.mem_to_reg_i,
        reg_write:  bus.reg_write_i
    };

    pipe_skid_buffer #(.W(ENTRY_W)) u_skid (
        .clk       (clk_i),
        .rst       (reset_i),
        .flush     (bus.flush_i),
        .in_valid  (bus.in_valid_i),
        .in_ready  (bus.in_ready_o),
        .in_data   (in_entry),
        .out_valid (main_valid),
        .out_ready (bus.out_ready_i),
        .out_data  (main_bits)
    );

    assign main_entry = memwb_entry_t'(main_bits);

    always_comb begin
        wb_mux = '0;
        case (main_entry.mem_to_reg)
            WB_SEL_ALU:  wb_mux = main_entry.alu_result;
            WB_SEL_MEM:  wb_mux = main_entry.data_read;
            WB_SEL_PC4:  wb_mux = main_entry.pc_plus4;
            default:     wb_mux = '0;
        endcase
    end

    // payload is gated so stale main contents never leak out while the stage is empty
    assign bus.out_valid_o  = main_valid;
    assign bus.data_read_o  = main_valid ? main_entry.data_read  : '0;
    assign bus.alu_result_o = main_valid ? main_entry.alu_result : '0;
    assign bus.pc_plus4_o   = main_valid ? main_entry.pc_plus4   : '0;
    assign bus.write_reg_o  = main_valid ? main_entry.write_reg  : '0;
    assign bus.mem_to_reg_o = main_valid ? main_entry.mem_to_reg : '0;
    assign bus.reg_write_o  = main_valid & main_entry.reg_write & (main_entry.write_reg != '0);
    assign bus.wb_data_o    = main_valid ? wb_mux : '0;

    assign drain = main_valid & bus.out_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)    retired_q <= '0;
        else if (drain) retired_q <= retired_q + 1'b1;
    end

    assign bus.retired_o = retired_q;
endmodule
